// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: 32-byte text frame buffer for a 2x16 character LCD.
// Accepts an ASCII stream over valid/ready and interprets LF, BS and FF.
// Line 1 occupies addresses 0-15 and line 2 occupies addresses 16-31.
// Optional feature: define LCD_TEXT_AUTOSCROLL_EN so that overflowing line 2
// scrolls line 2 into line 1 instead of wrapping the cursor back to 0.
`timescale 1ns/1ps
module lcd_text_buffer #(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [4:0] cursor_pos,
    output logic       frame_dirty,
    input  logic       frame_ack
);
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;

    typedef enum logic [1:0] {
        S_INIT_CLEAR = 2'd0,
        S_IDLE       = 2'd1,
        S_CLEAR      = 2'd2
`ifdef LCD_TEXT_AUTOSCROLL_EN
        , S_SCROLL   = 2'd3
`endif
    } state_t;

    state_t     state, state_next;
    logic [4:0] idx, idx_next;
    logic [4:0] cursor, cursor_next;
    logic       set_dirty;
    logic       is_printable;
    logic [7:0] mem [0:31];

    // Port A serves character writes, clears and the line-1 half of a scroll.
    logic       we_a;
    logic [4:0] addr_a;
    logic [7:0] data_a;
`ifdef LCD_TEXT_AUTOSCROLL_EN
    // Port B blanks line 2 while a scroll copies it upward.
    logic       we_b;
    logic [4:0] addr_b;
`endif

    assign is_printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign in_ready     = (state == S_IDLE);
    assign cursor_pos   = cursor;

    // Next-state, cursor and buffer-write decode for the current state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        idx_next   = idx;
        cursor_next = cursor;
        set_dirty  = 1'b0;
        we_a       = 1'b0;
        addr_a     = idx;
        data_a     = FILL_CHAR;
`ifdef LCD_TEXT_AUTOSCROLL_EN
        we_b       = 1'b0;
        addr_b     = {1'b1, idx[3:0]};
`endif
        case (state)
            S_INIT_CLEAR, S_CLEAR: begin
                we_a     = 1'b1;
                idx_next = idx + 5'd1;
                if (idx == 5'd31) begin
                    state_next  = S_IDLE;
                    cursor_next = '0;
                    set_dirty   = 1'b1;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    if (is_printable) begin
                        we_a      = 1'b1;
                        addr_a    = cursor;
                        data_a    = in_data;
                        set_dirty = 1'b1;
                        if (cursor != 5'd31) begin
                            cursor_next = cursor + 5'd1;
                        end else begin
`ifdef LCD_TEXT_AUTOSCROLL_EN
                            state_next = S_SCROLL;
                            idx_next   = '0;
`else
                            cursor_next = '0;
`endif
                        end
                    end else if (in_data == CH_LF) begin
                        if (!cursor[4]) begin
                            cursor_next = 5'd16;
                        end else begin
`ifdef LCD_TEXT_AUTOSCROLL_EN
                            state_next = S_SCROLL;
                            idx_next   = '0;
`else
                            cursor_next = '0;
`endif
                        end
                    end else if (in_data == CH_BS) begin
                        if (cursor != 5'd0) begin
                            cursor_next = cursor - 5'd1;
                            we_a        = 1'b1;
                            addr_a      = cursor - 5'd1;
                            set_dirty   = 1'b1;
                        end
                    end else if (in_data == CH_FF) begin
                        state_next = S_CLEAR;
                        idx_next   = '0;
                    end
                end
            end
`ifdef LCD_TEXT_AUTOSCROLL_EN
            S_SCROLL: begin
                we_a     = 1'b1;
                addr_a   = {1'b0, idx[3:0]};
                data_a   = mem[{1'b1, idx[3:0]}];
                we_b     = 1'b1;
                idx_next = idx + 5'd1;
                if (idx == 5'd15) begin
                    state_next  = S_IDLE;
                    idx_next    = '0;
                    cursor_next = 5'd16;
                    set_dirty   = 1'b1;
                end
            end
`endif
            default: begin
                state_next = S_INIT_CLEAR;
                idx_next   = '0;
            end
        endcase
    end

    // Control registers, dirty flag (set wins over ack) and registered read port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_INIT_CLEAR;
            idx         <= '0;
            cursor      <= '0;
            frame_dirty <= 1'b0;
            rd_data     <= 8'h00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state       <= state_next;
            idx         <= idx_next;
            cursor      <= cursor_next;
            frame_dirty <= set_dirty | (frame_dirty & ~frame_ack);
            rd_data     <= mem[rd_addr];
        end
    end

    // Character array writes; held off while reset is asserted.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset of its own; INIT_CLEAR fills every entry before in_ready rises.
        if (rst) begin
            if (we_a) mem[addr_a] <= data_a;
`ifdef LCD_TEXT_AUTOSCROLL_EN
            if (we_b) mem[addr_b] <= FILL_CHAR;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb_lcd_text_buffer: directed bench for lcd_text_buffer with an
// operation-level reference model and a per-cycle output comparator.
`timescale 1ns/1ps
module tb_lcd_text_buffer;
    localparam logic [7:0] FILL = 8'h20;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [4:0] cursor_pos;
    logic       frame_dirty;
    logic       frame_ack;

    int n_pass  = 0;
    int n_total = 0;

    lcd_text_buffer #(.FILL_CHAR(FILL)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .cursor_pos  (cursor_pos),
        .frame_dirty (frame_dirty),
        .frame_ack   (frame_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // The model treats clear and scroll as whole operations that finish
    // after a fixed number of busy cycles; only their end result is modelled.
    logic [7:0] exp_buf [32];
    int         exp_cursor   = 0;
    int         exp_busy     = 32;
    bit         exp_scroll   = 0;
    bit         exp_dirty    = 0;
    bit         exp_in_reset = 1;
    bit         exp_rd_valid = 0;
    logic [7:0] exp_rd       = 8'h00;
    bit         m_set;
    bit         cmp_en       = 0;
    bit         rd_sweep     = 1;

    always @(posedge clk) begin
        if (!rst) begin
            exp_in_reset = 1;
            exp_busy     = 32;
            exp_scroll   = 0;
            exp_cursor   = 0;
            exp_dirty    = 0;
            exp_rd_valid = 0;
        end else begin
            exp_in_reset = 0;
            exp_rd_valid = (exp_busy == 0);
            exp_rd       = exp_buf[rd_addr];
            m_set        = 0;
            if (exp_busy > 0) begin
                exp_busy--;
                if (exp_busy == 0) begin
                    if (exp_scroll) begin
                        for (int i = 0; i < 16; i++) begin
                            exp_buf[i]      = exp_buf[16 + i];
                            exp_buf[16 + i] = FILL;
                        end
                        exp_cursor = 16;
                    end else begin
                        for (int i = 0; i < 32; i++) exp_buf[i] = FILL;
                        exp_cursor = 0;
                    end
                    m_set = 1;
                end
            end else if (in_valid) begin
                if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                    exp_buf[exp_cursor] = in_data;
                    m_set = 1;
                    if (exp_cursor < 31) exp_cursor++;
                    else begin
`ifdef LCD_TEXT_AUTOSCROLL_EN
                        exp_busy = 16; exp_scroll = 1;
`else
                        exp_cursor = 0;
`endif
                    end
                end else if (in_data == 8'h0A) begin
                    if (exp_cursor < 16) exp_cursor = 16;
                    else begin
`ifdef LCD_TEXT_AUTOSCROLL_EN
                        exp_busy = 16; exp_scroll = 1;
`else
                        exp_cursor = 0;
`endif
                    end
                end else if (in_data == 8'h08) begin
                    if (exp_cursor > 0) begin
                        exp_cursor--;
                        exp_buf[exp_cursor] = FILL;
                        m_set = 1;
                    end
                end else if (in_data == 8'h0C) begin
                    exp_busy = 32; exp_scroll = 0;
                end
            end
            if (m_set) exp_dirty = 1;
            else if (frame_ack) exp_dirty = 0;
        end
    end

    // Per-cycle comparison of DUT outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            if (exp_in_reset) begin
                check("reset_in_ready", in_ready, 0);
                check("reset_dirty", frame_dirty, 0);
                check("reset_cursor", cursor_pos, 0);
                check("reset_rd_data", rd_data, 8'h00);
            end else begin
                check("in_ready", in_ready, exp_busy == 0);
                check("frame_dirty", frame_dirty, exp_dirty);
                if (exp_busy == 0) check("cursor_pos", cursor_pos, exp_cursor);
                if (exp_rd_valid) check("rd_data", rd_data, exp_rd);
            end
        end
    end

    // Free-running read address sweep so the comparator covers all addresses.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_sweep) rd_addr = rd_addr + 5'd1;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send(input logic [7:0] b, input logic ack = 1'b0);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin n++; @(negedge clk); end
        if (n >= 200) check("send_ready_timeout", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = b;
        frame_ack = ack;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic ack_only();
        @(negedge clk);
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
    endtask

    // Counts ready-low cycles starting at the current (negedge) cycle.
    task automatic count_busy(input string name, input int expected);
        int n = 0;
        while (!in_ready && n < 100) begin n++; @(negedge clk); end
        check(name, n, expected);
    endtask

    task automatic read_check(input string name, input logic [4:0] a, input logic [7:0] expected);
        rd_sweep = 0;
        @(negedge clk);
        rd_addr = a;
        @(posedge clk); #1;
        check(name, rd_data, expected);
        rd_sweep = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; frame_ack = 1'b0; rd_addr = 5'd0;
        repeat (3) @(posedge clk);
        #1 cmp_en = 1;

        // Reset release: 32 ready-low cycles, blank screen, dirty, cursor 0.
        @(negedge clk);
        rst = 1'b1;
        count_busy("init_ready_low_cycles", 32);
        check("init_cursor", cursor_pos, 0);
        check("init_dirty", frame_dirty, 1);
        for (int a = 0; a < 32; a++) read_check("init_blank", 5'(a), 8'h20);

        // Same-cycle read and write to address 0 returns the old byte.
        rd_sweep = 0;
        @(negedge clk);
        rd_addr = 5'd0; in_valid = 1'b1; in_data = 8'h48;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rd_pre_write", rd_data, 8'h20);
        rd_sweep = 1;

        // Text and newline: "HI\nOK".
        send(8'h49); send(8'h0A); send(8'h4F); send(8'h4B);
        check("text_cursor", cursor_pos, 18);
        read_check("text_b0", 5'd0, 8'h48);
        read_check("text_b1", 5'd1, 8'h49);
        read_check("text_b16", 5'd16, 8'h4F);
        read_check("text_b17", 5'd17, 8'h4B);

        // Backspace across the line boundary, down to cursor 15.
        send(8'h08); send(8'h08); send(8'h08);
        check("bs_cursor", cursor_pos, 15);
        read_check("bs_b15", 5'd15, 8'h20);
        read_check("bs_b16", 5'd16, 8'h20);

        // Form feed: 32 ready-low cycles, then cursor 0.
        send(8'h0C);
        @(negedge clk);
        count_busy("ff_ready_low_cycles", 32);
        check("ff_cursor", cursor_pos, 0);
        read_check("ff_b0", 5'd0, 8'h20);

        // Backspace at cursor 0 and an unknown control byte do nothing.
        ack_only();
        check("ack_clears_dirty", frame_dirty, 0);
        send(8'h08);
        check("bs0_cursor", cursor_pos, 0);
        check("bs0_dirty", frame_dirty, 0);
        send(8'h01);
        check("other_dirty", frame_dirty, 0);
        check("other_cursor", cursor_pos, 0);

        // Ack colliding with a printable: set wins, then ack alone clears.
        send(8'h5A, 1'b1);
        check("collide_dirty", frame_dirty, 1);
        ack_only();
        check("ack_after_collide", frame_dirty, 0);

        // Wrap / scroll at the end of line 2.
        send(8'h0C);
        @(negedge clk);
        count_busy("ff2_ready_low_cycles", 32);
        for (int i = 0; i < 32; i++) send(8'(8'h41 + i));
`ifdef LCD_TEXT_AUTOSCROLL_EN
        @(negedge clk);
        count_busy("scroll_ready_low_cycles", 16);
        check("scroll_cursor", cursor_pos, 16);
        for (int i = 0; i < 16; i++) read_check("scroll_line1", 5'(i), 8'(8'h51 + i));
        read_check("scroll_b16", 5'd16, 8'h20);
        send(8'h78);
        read_check("scroll_x", 5'd16, 8'h78);
        check("scroll_x_cursor", cursor_pos, 17);
        send(8'h0A);
        @(negedge clk);
        count_busy("lf_scroll_ready_low_cycles", 16);
        check("lf_scroll_cursor", cursor_pos, 16);
        read_check("lf_scroll_b0", 5'd0, 8'h78);
        read_check("lf_scroll_b16", 5'd16, 8'h20);
`else
        check("wrap_cursor", cursor_pos, 0);
        read_check("wrap_b31", 5'd31, 8'h60);
        send(8'h78);
        read_check("wrap_x", 5'd0, 8'h78);
        check("wrap_x_cursor", cursor_pos, 1);
        send(8'h0A);
        check("lf_to_line2", cursor_pos, 16);
        send(8'h0A);
        check("lf_wrap_cursor", cursor_pos, 0);
`endif

        // Form feed aborted by reset at clear index 10.
        send(8'h0C);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        count_busy("abort_ready_low_cycles", 32);
        check("abort_cursor", cursor_pos, 0);
        check("abort_dirty", frame_dirty, 1);
        read_check("abort_b10", 5'd10, 8'h20);
        read_check("abort_b31", 5'd31, 8'h20);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
